// File: rtl/sra_pipe_pkg.sv
// Shared shift-path definitions: widths, latency, ALU shift opcodes and the
// 2:1 mux cell used to build the shifter stages.
package sra_pipe_pkg;

  localparam int unsigned SHIFT_W   = 32;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned SHIFT_LAT = 5;

  typedef enum logic [1:0] {
    ALU_SLL = 2'd0,
    ALU_SRL = 2'd1,
    ALU_SRA = 2'd2
  } alu_shift_op_e;

  // Single-bit 2:1 mux cell: sel = 0 picks a, sel = 1 picks b.
  function automatic logic mux2(input logic sel, input logic a, input logic b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/sra_pipe_stage.sv
// One pipeline stage of the right shifter: optional STEP-bit right shift
// with a carried fill bit, followed by the stage register.
module sr_stage
  import sra_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_W,
  parameter int unsigned SHW   = SHAMT_W,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic             fill_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   shamt_o,
  output logic             fill_o
);

  localparam int unsigned SEL = $clog2(STEP);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   shamt_q;
  logic             fill_q;
  logic             valid_q;

  assign shifted = {{STEP{fill_i}}, data_i[WIDTH-1:STEP]};

  // Per-bit select between pass-through and shifted operand.
  always_comb begin
    data_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      data_d[i] = mux2(shamt_i[SEL], data_i[i], shifted[i]);
    end
  end

  // Stage register: loads together with every other stage when the pipe advances.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      fill_q  <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      shamt_q <= shamt_i;
      fill_q  <= fill_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign fill_o  = fill_q;

endmodule

// File: rtl/sra_pipe.sv
// Pipelined logical/arithmetic right barrel shifter, one power-of-two step
// per registered stage, valid/ready on both sides with full backpressure.
module sra_pipe
  import sra_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_W,
  parameter int unsigned SHW   = SHAMT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             adv;
  logic             vld_c   [0:SHW];
  logic [WIDTH-1:0] data_c  [0:SHW];
  logic [SHW-1:0]   shamt_c [0:SHW];
  logic             fill_c  [0:SHW];
  logic             unused_tail;

  // Whole pipe moves as one; it only freezes when a finished result is refused.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Fill bit is fixed at accept from the original sign, never from shifted data.
  assign vld_c[0]   = in_valid;
  assign data_c[0]  = in_data;
  assign shamt_c[0] = in_shamt;
  assign fill_c[0]  = in_arith & in_data[WIDTH-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    sr_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .STEP  (2 ** k)
    ) u_stage (
      .clk_i   (clock),
      .rst_i   (reset),
      .en_i    (adv),
      .valid_i (vld_c[k]),
      .data_i  (data_c[k]),
      .shamt_i (shamt_c[k]),
      .fill_i  (fill_c[k]),
      .valid_o (vld_c[k+1]),
      .data_o  (data_c[k+1]),
      .shamt_o (shamt_c[k+1]),
      .fill_o  (fill_c[k+1])
    );
  end

  assign out_valid   = vld_c[SHW];
  assign out_data    = data_c[SHW];
  assign unused_tail = ^{shamt_c[SHW], fill_c[SHW]};

endmodule
